// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode seven-segment scan driver for the 20-bit lock symbol bus.
// Optional 1 Hz digit blinking is compiled in when SSD_BLINK_EN is defined.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_HALF  = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  AN,
  output logic [6:0]  seven_out
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [4:0] CODE_BLANK = 5'b10011;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG3 = 2'd3;

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [19:0]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic          frame_load;
  logic          phase;
  logic [3:0]    mask_snap;
  logic [4:0]    digit_code [4];
  logic [4:0]    cur_code;

  // Segment patterns are active-low, ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'd0:    seg = 7'b0000001;
      5'd1:    seg = 7'b1001111;
      5'd2:    seg = 7'b0010010;
      5'd3:    seg = 7'b0000110;
      5'd4:    seg = 7'b1001100;
      5'd5:    seg = 7'b0100100;
      5'd6:    seg = 7'b0100000;
      5'd7:    seg = 7'b0001111;
      5'd8:    seg = 7'b0000000;
      5'd9:    seg = 7'b0000100;
      5'd10:   seg = 7'b0110001;
      5'd11:   seg = 7'b1110001;
      5'd12:   seg = 7'b0100100;
      5'd13:   seg = 7'b1000010;
      5'd14:   seg = 7'b0000001;
      5'd15:   seg = 7'b0011000;
      5'd16:   seg = 7'b0110000;
      5'd17:   seg = 7'b1101010;
      5'd18:   seg = 7'b1111110;
      5'd20:   seg = 7'b1111010;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_code[gi] = snap_q[gi*5 +: 5];
    end
  endgenerate

  assign tick       = (ref_cnt_q == REF_LAST);
  assign frame_load = tick && (idx_q == DIG0);
  assign cur_code   = digit_code[idx_q];

  always_comb begin
    ref_cnt_d = tick ? '0 : ref_cnt_q + RW'(1);
    idx_d     = tick ? idx_q - 2'd1 : idx_q;
    snap_d    = frame_load ? ssd : snap_q;
  end

`ifdef SSD_BLINK_EN
  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    mask_q, mask_d;

  // Free-running: snapshot loads never restart the blink period.
  always_comb begin
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
    phase_d     = (blink_cnt_q == BLINK_LAST) ? ~phase_q : phase_q;
    mask_d      = frame_load ? blink_mask : mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      mask_q      <= 4'b0000;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      mask_q      <= mask_d;
    end
  end

  assign phase     = phase_q;
  assign mask_snap = mask_q;
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign phase             = 1'b1;
  assign mask_snap         = 4'b0000;
`endif

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = decode(cur_code);
    if (!phase && mask_snap[idx_q]) begin
      an_d  = 4'b1111;
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q <= '0;
      idx_q     <= DIG0;
      snap_q    <= {4{CODE_BLANK}};
      an_q      <= 4'b1111;
      seg_q     <= SEG_OFF;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign AN        = an_q;
  assign seven_out = seg_q;

  // Scan order relies on idx wrapping 0 -> 3 at the frame boundary.
  logic unused_dig3;
  assign unused_dig3 = ^DIG3;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized bench for ssd_scan_driver against a cycle-count-based reference model.
// Blink expectations follow SSD_BLINK_EN as defined for the build.
module tb_ssd_scan_driver;

  localparam int RD = 4;
  localparam int BH = 32;
`ifdef SSD_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [19:0] ssd;
  logic [3:0]  blink_mask;
  logic [3:0]  AN;
  logic [6:0]  seven_out;

  int vectors;
  int miscompares;
  int n;
  logic [19:0] ssd_hist  [0:4095];
  logic [3:0]  mask_hist [0:4095];

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLINK_HALF(BH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ssd        (ssd),
    .blink_mask (blink_mask),
    .AN         (AN),
    .seven_out  (seven_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  // Glyphs described by their lit segment letters, converted to active-low {a..g}.
  function automatic logic [6:0] seg_model(input int code);
    string s;
    logic [6:0] r;
    case (code)
      0: s = "abcdef";   1: s = "bc";      2: s = "abdeg";   3: s = "abcdg";
      4: s = "bcfg";     5: s = "acdfg";   6: s = "acdefg";  7: s = "abc";
      8: s = "abcdefg";  9: s = "abcdfg";  10: s = "adef";   11: s = "def";
      12: s = "acdfg";   13: s = "bcdeg";  14: s = "abcdef"; 15: s = "abefg";
      16: s = "adefg";   17: s = "ceg";    18: s = "g";      20: s = "eg";
      default: s = "";
    endcase
    r = 7'h7f;
    for (int i = 0; i < s.len(); i++) r[6 - int'(s[i] - "a")] = 1'b0;
    return r;
  endfunction

  // Edge number at which the snapshot in force after m edges was captured.
  function automatic int snap_edge(input int m);
    int k;
    k = m / RD;
    if (k < 1) return -1;
    return (k - ((k - 1) % 4)) * RD;
  endfunction

  function automatic int shown_idx(input int m);
    return (4 - ((m / RD) % 4)) % 4;
  endfunction

  task automatic check_model();
    int m, id, e;
    logic [19:0] sn;
    logic [3:0]  mk;
    bit          ph, sup;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    sup = 1'b0;
    if (n == 0) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7f;
    end else begin
      m  = n - 1;
      id = shown_idx(m);
      e  = snap_edge(m);
      sn = (e < 0) ? {4{5'd19}} : ssd_hist[e];
      mk = (e < 0) ? 4'b0000 : mask_hist[e];
      ph = ((m / BH) % 2) == 0;
      sup = BLINK_ON && !ph && mk[id];
      exp_an  = sup ? 4'hF : (4'hF ^ (4'b0001 << id));
      exp_seg = seg_model(int'(sn[id*5 +: 5]));
    end
    check_eq("an", {28'd0, AN}, {28'd0, exp_an});
    if (!sup) check_eq("seg", {25'd0, seven_out}, {25'd0, exp_seg});
  endtask

  task automatic cycle();
    @(posedge clk);
    n++;
    ssd_hist[n]  = ssd;
    mask_hist[n] = blink_mask;
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_an", {28'd0, AN}, 32'hF);
    check_eq("rst_seg", {25'd0, seven_out}, 32'h7f);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    check_model();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n           = 0;
    rst         = 1'b0;
    ssd         = 20'h0;
    blink_mask  = 4'b0000;
    #1 rst = 1'b1;
    #1;
    check_eq("por_an", {28'd0, AN}, 32'hF);
    check_eq("por_seg", {25'd0, seven_out}, 32'h7f);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_model();

    // C L S d, then O P E n requested while digit 2 is lit
    ssd = 20'h52D8D;
    while (n < RD + 1) cycle();
    check_eq("C_an", {28'd0, AN}, 32'h7);
    check_eq("C_glyph", {25'd0, seven_out}, 32'b0110001);
    while (n < 2 * RD + 2) cycle();
    check_eq("L_an", {28'd0, AN}, 32'hB);
    ssd = 20'h73E11;
    while (n < 3 * RD + 1) cycle();
    check_eq("S_glyph", {25'd0, seven_out}, 32'b0100100);
    while (n < 5 * RD + 1) cycle();
    check_eq("O_glyph", {25'd0, seven_out}, 32'b0000001);
    run(4 * RD * 2);

    // dash, blank code 19 and unused code 25
    ssd = 20'h44A79;
    run(8 * RD);
    for (int i = 0; i < 4 * RD; i++) begin
      cycle();
      if (shown_idx(n - 1) == 2) check_eq("dash", {25'd0, seven_out}, 32'b1111110);
      if (shown_idx(n - 1) < 2) begin
        check_eq("blank_seg", {25'd0, seven_out}, 32'h7f);
        check_eq("blank_an_on", {31'd0, AN == 4'hF}, 32'd0);
      end
    end

    if (BLINK_ON) begin
      ssd        = 20'h04A52;
      blink_mask = 4'b1000;
      run(5 * BH);
    end else begin
      blink_mask = 4'b1111;
      run(8 * RD);
      for (int i = 0; i < 200; i++) begin
        cycle();
        check_eq("lit", {31'd0, AN == 4'hF}, 32'd0);
      end
    end

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) ssd = 20'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      cycle();
    end

    // asynchronous reset in the middle of a slot
    run(RD + 2);
    do_reset();
    ssd        = 20'h52D8D;
    blink_mask = 4'b0000;
    while (n < RD + 1) cycle();
    check_eq("first_d3", {28'd0, AN}, 32'h7);
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
